// File: rtl/uart_sample_sender.sv
// uart_sample_sender: buffers 16-bit samples in a small FIFO and feeds them as two bytes to a UART transmitter.
//   clkIn          sole clock, rising edge
//   resetIn        synchronous active-high reset
//   sampleIn       16-bit sample word
//   sampleValidIn  sampleIn valid this cycle
//   sampleReadyOut FIFO not full (low during reset)
//   txReadyIn      UART transmitter ready
//   txLoadOut      one-cycle load strobe to the transmitter
//   txDataOut      byte for the transmitter, held until the next load
//   levelOut       FIFO occupancy
//   busyOut        FSM active or FIFO not empty
module uart_sample_sender #(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                          clkIn,
    input  logic                          resetIn,
    input  logic [15:0]                   sampleIn,
    input  logic                          sampleValidIn,
    output logic                          sampleReadyOut,
    input  logic                          txReadyIn,
    output logic                          txLoadOut,
    output logic [7:0]                    txDataOut,
    output logic [$clog2(FIFO_DEPTH):0]   levelOut,
    output logic                          busyOut
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B} stateType;
    stateType state;
    logic [15:0] fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [15:0] holdReg;
    logic push, pop, notEmpty;
    logic [7:0] firstByte, secondByte;
    assign notEmpty = levelOut != '0;
    // Readiness depends only on the registered level, so a same-cycle pop never frees room for a push.
    assign sampleReadyOut = !resetIn && levelOut != (AW+1)'(FIFO_DEPTH);
    assign push = sampleValidIn && sampleReadyOut;
    // Pop from IDLE, or straight out of WAIT_B so back-to-back samples have no idle bubble.
    assign pop = notEmpty && (state == IDLE || (state == WAIT_B && !txReadyIn));
    assign busyOut = state != IDLE || notEmpty;
    assign firstByte = MSB_FIRST ? holdReg[15:8] : holdReg[7:0];
    assign secondByte = MSB_FIRST ? holdReg[7:0] : holdReg[15:8];
    // Storage is unreset; an empty level is enough to discard its contents.
    always_ff @(posedge clkIn)
        if (push) fifoMem[wrPtr] <= sampleIn;
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state <= IDLE;
            wrPtr <= '0;
            rdPtr <= '0;
            levelOut <= '0;
            holdReg <= '0;
            txLoadOut <= 1'b0;
            txDataOut <= 8'h00;
        end else begin
            txLoadOut <= 1'b0;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) begin
                holdReg <= fifoMem[rdPtr];
                rdPtr <= rdPtr + 1'b1;
            end
            levelOut <= levelOut + (AW+1)'(push) - (AW+1)'(pop);
            case (state)
                IDLE: if (notEmpty) state <= SEND_A;
                SEND_A: if (txReadyIn) begin
                    txLoadOut <= 1'b1;
                    txDataOut <= firstByte;
                    state <= WAIT_A;
                end
                // Wait for the transmitter to drop ready so the same byte is never loaded twice.
                WAIT_A: if (!txReadyIn) state <= SEND_B;
                SEND_B: if (txReadyIn) begin
                    txLoadOut <= 1'b1;
                    txDataOut <= secondByte;
                    state <= WAIT_B;
                end
                WAIT_B: if (!txReadyIn) state <= notEmpty ? SEND_A : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_sample_sender.sv
// tb_uart_sample_sender: scoreboard bench driving two senders (LSB-first and MSB-first) with shared stimulus.
module tb_uart_sample_sender;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetIn, sampleValidIn, txReady;
    logic [15:0] sampleIn;
    logic ready0, load0, busy0, ready1, load1, busy1;
    logic [7:0] data0, data1;
    logic [2:0] level0, level1;
    int readyMode, gapLen, gapCnt;
    int checks = 0, errors = 0, loads0 = 0;
    logic [7:0] q0[$], q1[$];
    logic prev0, prev1;
    logic [7:0] last0, last1;

    uart_sample_sender #(.FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut0 (
        .clkIn(clk), .resetIn(resetIn), .sampleIn(sampleIn), .sampleValidIn(sampleValidIn),
        .sampleReadyOut(ready0), .txReadyIn(txReady), .txLoadOut(load0), .txDataOut(data0),
        .levelOut(level0), .busyOut(busy0));
    uart_sample_sender #(.FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut1 (
        .clkIn(clk), .resetIn(resetIn), .sampleIn(sampleIn), .sampleValidIn(sampleValidIn),
        .sampleReadyOut(ready1), .txReadyIn(txReady), .txLoadOut(load1), .txDataOut(data1),
        .levelOut(level1), .busyOut(busy1));

    // Transmitter model: ready drops for gapLen cycles after each load; readyMode 1/2 forces low/high.
    always @(posedge clk)
        if (resetIn) gapCnt <= 0;
        else if (load0) gapCnt <= gapLen;
        else if (gapCnt > 0) gapCnt <= gapCnt - 1;
    assign txReady = readyMode == 1 ? 1'b0 : readyMode == 2 ? 1'b1 : gapCnt == 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Input monitor: every accepted sample becomes its two expected bytes per byte order.
    always @(posedge clk)
        if (resetIn) begin
            q0.delete();
            q1.delete();
        end else if (sampleValidIn && ready0) begin
            q0.push_back(sampleIn[7:0]);
            q0.push_back(sampleIn[15:8]);
            q1.push_back(sampleIn[15:8]);
            q1.push_back(sampleIn[7:0]);
        end

    // Output monitor: compare each load against the scoreboard, check pulse width and data hold.
    always @(negedge clk)
        if (resetIn) begin
            prev0 = 1'b0; prev1 = 1'b0; last0 = 8'h00; last1 = 8'h00;
        end else begin
            if (load0) begin
                chk("pulse0", {31'b0, prev0}, 0);
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extraLoad0 actual=%0h required=none", data0);
                end else chk("byte0", data0, q0.pop_front());
                last0 = data0;
                loads0++;
            end else chk("hold0", data0, last0);
            if (load1) begin
                chk("pulse1", {31'b0, prev1}, 0);
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extraLoad1 actual=%0h required=none", data1);
                end else chk("byte1", data1, q1.pop_front());
                last1 = data1;
            end else chk("hold1", data1, last1);
            prev0 = load0;
            prev1 = load1;
        end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushOne(logic [15:0] d);
        sampleIn = d;
        sampleValidIn = 1'b1;
        @(negedge clk);
        sampleValidIn = 1'b0;
    endtask

    task automatic pushWait(logic [15:0] d);
        int n = 0;
        while (!ready0 && n < 1000) begin tick(1); n++; end
        chk("readyWait", {31'b0, n < 1000}, 1);
        pushOne(d);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && n < 3000) begin tick(1); n++; end
        chk("drained", {31'b0, n < 3000}, 1);
        chk("busyIdle", {30'b0, busy1, busy0}, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int l, n;
        resetIn = 1'b1; sampleValidIn = 1'b0; sampleIn = '0; readyMode = 0; gapLen = 10;
        tick(3);
        chk("rstLevel", level0, 0);
        chk("rstLoad", load0, 0);
        chk("rstData", data0, 0);
        chk("rstBusy", busy0, 0);
        chk("rstReady", {30'b0, ready1, ready0}, 0);
        resetIn = 1'b0;
        // Push on the first cycle after reset; load appears exactly 2 cycles after the push cycle.
        pushOne(16'hA55A);
        chk("lat1", load0, 0);
        tick(1);
        chk("lat2", load0, 0);
        tick(1);
        chk("latLoad", load0, 1);
        chk("latData", data0, 8'h5A);
        drain();
        pushOne(16'h1234);
        drain();
        // Fill with the transmitter stalled: one sample held, four buffered, sixth ignored.
        readyMode = 1;
        for (int i = 1; i <= 5; i++) pushOne(16'(i));
        chk("fullLevel", level0, 4);
        chk("fullReady", ready0, 0);
        pushOne(16'h0006);
        chk("fullLevelAfter", level0, 4);
        readyMode = 0;
        drain();
        // Stuck-high ready in WAIT_A, then a push coinciding with the WAIT_B pop at level 2.
        readyMode = 1;
        pushOne(16'h1111); pushOne(16'h2222); pushOne(16'h3333);
        tick(2);
        chk("level2", level0, 2);
        l = loads0;
        readyMode = 2;
        tick(5);
        chk("stuckOneLoad", loads0 - l, 1);
        readyMode = 1;
        tick(2);
        readyMode = 2;
        tick(3);
        chk("secondLoad", loads0 - l, 2);
        readyMode = 1;
        pushOne(16'h4444);
        chk("simulLevel", level0, 2);
        readyMode = 0;
        for (int i = 0; i < 8; i++) pushWait(16'($urandom));
        drain();
        // Randomised traffic with varying transmitter gaps and occasional stalls.
        for (int i = 0; i < 300; i++) begin
            readyMode = $urandom_range(0, 9) == 0 ? 1 : 0;
            gapLen = $urandom_range(1, 12);
            if ($urandom_range(0, 1) == 1) pushOne(16'($urandom));
            else tick(1);
        end
        readyMode = 0;
        gapLen = 10;
        drain();
        // Reset after the first byte of BEEF: its second byte must never be loaded.
        l = loads0;
        pushOne(16'hBEEF);
        n = 0;
        while (loads0 == l && n < 100) begin tick(1); n++; end
        chk("beefFirstLoad", loads0 - l, 1);
        resetIn = 1'b1;
        tick(1);
        chk("midRstLevel", level0, 0);
        chk("midRstLoad", load0, 0);
        resetIn = 1'b0;
        tick(30);
        chk("noStrayLoad", loads0 - l, 1);
        pushOne(16'h0102);
        drain();
        chk("q0Empty", q0.size(), 0);
        chk("q1Empty", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
